// File: rtl/tcam_match_decoder_pkg.sv
// tcam_pkg: shared definitions for the FracTCAM match decoder.
//   DEPTH_DEF      default number of TCAM entries
//   MAX_DEPTH      widest match vector the helper functions handle
//   idx_w()        index width for a given depth (never below 1)
//   lsb_index()    position of the lowest set bit (0 for an all-zero vector)
//   single_or_zero() true when at most one bit of the vector is set
package tcam_pkg;

  localparam int DEPTH_DEF = 64;

  // The helpers take a fixed-width vector. Narrower vectors are zero-extended
  // by the caller. Zero-extension changes neither the lowest set bit nor the
  // popcount, so results match a DEPTH-wide computation.
  localparam int MAX_DEPTH = 512;

  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Scans from the top down so that the last assignment is the lowest set bit.
  function automatic int lsb_index(input logic [MAX_DEPTH-1:0] v);
    int r;
    r = 0;
    for (int i = MAX_DEPTH - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  // x & (x-1) clears the lowest set bit; a zero result means at most one bit
  // was set. An all-zero vector also yields zero.
  function automatic logic single_or_zero(input logic [MAX_DEPTH-1:0] v);
    logic [MAX_DEPTH-1:0] v_m1;
    v_m1 = v - MAX_DEPTH'(1);
    return ((v & v_m1) == '0);
  endfunction

endpackage

// File: rtl/tcam_match_decoder_if.sv
// tcam_match_decoder_if: the two handshake streams around the match decoder.
//   Input stream : s_match / s_valid / s_ready  (match vector in)
//   Output stream: m_idx / m_hit / m_last / m_valid / m_ready  (indices out)
// Handshake rule for both streams: a beat transfers on a rising clock edge
// where valid and ready are both high. The sender holds its payload stable
// while valid is high and ready is low. Ready never depends on valid.
// Modports:
//   slave  - the decoder's view (consumes vectors, produces indices)
//   master - the environment's view (produces vectors, consumes indices)
interface tcam_match_decoder_if #(
  parameter int DEPTH = tcam_pkg::DEPTH_DEF,
  parameter int IDX_W = tcam_pkg::idx_w(DEPTH)
);

  logic [DEPTH-1:0] s_match;
  logic             s_valid;
  logic             s_ready;
  logic [IDX_W-1:0] m_idx;
  logic             m_hit;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;

  modport slave (
    input  s_match, s_valid, m_ready,
    output s_ready, m_idx, m_hit, m_last, m_valid
  );

  modport master (
    output s_match, s_valid, m_ready,
    input  s_ready, m_idx, m_hit, m_last, m_valid
  );

endinterface

// File: rtl/tcam_match_decoder_prio_enc.sv
// tcam_prio_enc: combinational lowest-set-bit encoder.
//   vec    [DEPTH-1:0] input vector
//   idx    [IDX_W-1:0] index of the lowest set bit (0 when vec is all zero)
//   any                at least one bit of vec is set
//   single             at most one bit of vec is set
module tcam_prio_enc
  import tcam_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = idx_w(DEPTH)
) (
  input  logic [DEPTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             single
);

  logic [MAX_DEPTH-1:0] vec_ext;

  assign vec_ext = MAX_DEPTH'(vec);
  assign idx     = IDX_W'(lsb_index(vec_ext));
  assign any     = |vec;
  assign single  = single_or_zero(vec_ext);

endmodule

// File: rtl/tcam_match_decoder.sv
// tcam_match_decoder: turns a TCAM match vector into a stream of hit indices,
// lowest index first, one per accepted output beat.
//   clk, rst_n  core clock, asynchronous active-low reset
//   bus         tcam_match_decoder_if.slave
//                 s_match/s_valid/s_ready   match vector input stream
//                 m_idx/m_hit/m_last/m_valid/m_ready   index output stream
//   dbg_state   current FSM state (ST_IDLE / ST_EMIT)
// A vector with k hits produces k beats. A vector with no hits produces one
// beat with m_hit=0, m_idx=0, m_last=1. The final beat of a vector can be
// followed by the next vector's first beat with no idle cycle.
module tcam_match_decoder
  import tcam_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = idx_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tcam_match_decoder_if.slave    bus,
  output logic [0:0]             dbg_state
);

  // The FSM state is exactly the output valid flag.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_depth_check
    $error("tcam_match_decoder: DEPTH out of supported range");
  end

  logic [DEPTH-1:0] pending;
  logic [IDX_W-1:0] m_idx_q;
  logic             m_hit_q;
  logic             m_last_q;
  logic             m_valid_q;

  logic [IDX_W-1:0] s_idx;
  logic             s_any;
  logic             s_single;
  logic [IDX_W-1:0] p_idx;
  logic             p_any;
  logic             p_single;

  logic             s_ready_c;
  logic             accept;
  logic             advance;

  // Encoder on the incoming vector, used when a new vector is loaded.
  tcam_prio_enc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_enc_s (
    .vec    (bus.s_match),
    .idx    (s_idx),
    .any    (s_any),
    .single (s_single)
  );

  // Encoder on the leftover hits, used for every beat after the first one.
  tcam_prio_enc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_enc_p (
    .vec    (pending),
    .idx    (p_idx),
    .any    (p_any),
    .single (p_single)
  );

  // A new vector can enter when nothing is being shown, or when the final beat
  // of the current vector is leaving on this edge.
  assign s_ready_c = !m_valid_q || (bus.m_ready && m_last_q);
  assign accept    = bus.s_valid && s_ready_c;
  assign advance   = m_valid_q && bus.m_ready && !m_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_idx_q   <= '0;
      m_hit_q   <= 1'b0;
      m_last_q  <= 1'b0;
      pending   <= '0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_idx_q   <= s_idx;
      m_hit_q   <= s_any;
      m_last_q  <= s_single;
      // Drop the lowest hit, which is the one being shown now.
      pending   <= bus.s_match & (bus.s_match - DEPTH'(1));
    end else if (advance) begin
      m_idx_q   <= p_idx;
      m_hit_q   <= p_any;
      m_last_q  <= p_single;
      pending   <= pending & (pending - DEPTH'(1));
    end else if (m_valid_q && bus.m_ready) begin
      // Final beat left and no new vector is waiting.
      m_valid_q <= 1'b0;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_idx   = m_idx_q;
  assign bus.m_hit   = m_hit_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_valid = m_valid_q;

  assign dbg_state = m_valid_q ? ST_EMIT : ST_IDLE;

endmodule

// File: tb/tb_tcam_match_decoder.sv
module tb_tcam_match_decoder;
  import tcam_pkg::*;

  localparam int DEPTH = 64;
  localparam int IDX_W = 6;

  logic       clk;
  logic       rst_n;
  logic [0:0] dbg_state;

  int tests_run;
  int tests_failed;

  // Scoreboard entries: {idx, last}
  logic [IDX_W:0] exp_q[$];

  tcam_match_decoder_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

  tcam_match_decoder #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic hit, input logic last);
    check({tag, ".valid"}, 64'(bus.m_valid), 64'd1);
    check({tag, ".idx"},   64'(bus.m_idx),   64'(idx));
    check({tag, ".hit"},   64'(bus.m_hit),   64'(hit));
    check({tag, ".last"},  64'(bus.m_last),  64'(last));
  endtask

  // Drains the beats listed in exp_q under random backpressure.
  task automatic drain_scoreboard(input string tag);
    logic [IDX_W:0] e;
    int budget;
    budget = 200;
    while (exp_q.size() > 0 && budget > 0) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.m_valid && bus.m_ready) begin
        e = exp_q.pop_front();
        check({tag, ".idx"},  64'(bus.m_idx),  64'(e[IDX_W:1]));
        check({tag, ".hit"},  64'(bus.m_hit),  64'd1);
        check({tag, ".last"}, 64'(bus.m_last), 64'(e[0]));
      end
      tick();
      budget--;
    end
    check({tag, ".drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.s_match  = '0;
    bus.s_valid  = 1'b0;
    bus.m_ready  = 1'b0;

    // Reset held with a valid vector presented.
    bus.s_valid = 1'b1;
    bus.s_match = 64'h10;
    repeat (3) tick();
    check("rst.m_valid", 64'(bus.m_valid), 64'd0);
    check("rst.s_ready", 64'(bus.s_ready), 64'd1);
    check("rst.m_idx",   64'(bus.m_idx),   64'd0);
    check("rst.m_hit",   64'(bus.m_hit),   64'd0);
    check("rst.m_last",  64'(bus.m_last),  64'd0);
    check("rst.state",   64'(dbg_state),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst.rel_pre", 64'(bus.m_valid), 64'd0);
    tick();
    check_beat("rst.first", 4, 1'b1, 1'b1);
    check("rst.state_emit", 64'(dbg_state), 64'd1);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    check("rst.idle", 64'(bus.m_valid), 64'd0);

    // Multi-hit: bits 0, 4, 63 on three consecutive cycles.
    bus.s_match = 64'h8000_0000_0000_0011;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    check_beat("multi.b0", 0, 1'b1, 1'b0);
    check("multi.s_ready0", 64'(bus.s_ready), 64'd0);
    tick();
    check_beat("multi.b1", 4, 1'b1, 1'b0);
    check("multi.s_ready1", 64'(bus.s_ready), 64'd0);
    tick();
    check_beat("multi.b2", 63, 1'b1, 1'b1);
    check("multi.s_ready2", 64'(bus.s_ready), 64'd1);
    tick();
    check("multi.done", 64'(bus.m_valid), 64'd0);

    // Empty vector: one beat, no hit.
    bus.s_match = '0;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    check_beat("nohit", 0, 1'b0, 1'b1);
    check("nohit.s_ready", 64'(bus.s_ready), 64'd1);
    tick();
    check("nohit.done", 64'(bus.m_valid), 64'd0);

    // Backpressure on 64'h6; s_match is disturbed (including X) while idle.
    bus.s_match = 64'h6;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b0;
    tick();
    bus.s_valid = 1'b0;
    bus.s_match = 'x;
    check_beat("bp.b0", 1, 1'b1, 1'b0);
    check("bp.s_ready0", 64'(bus.s_ready), 64'd0);
    tick();
    check_beat("bp.hold0a", 1, 1'b1, 1'b0);
    tick();
    check_beat("bp.hold0b", 1, 1'b1, 1'b0);
    bus.s_match = 64'hFFFF_0000_FFFF_0000;
    bus.m_ready = 1'b1;
    #1;
    check("bp.s_ready1", 64'(bus.s_ready), 64'd0);
    tick();
    check_beat("bp.b1", 2, 1'b1, 1'b1);
    bus.m_ready = 1'b0;
    #1;
    check("bp.s_ready2", 64'(bus.s_ready), 64'd0);
    tick();
    check_beat("bp.hold1", 2, 1'b1, 1'b1);
    bus.m_ready = 1'b1;
    #1;
    check("bp.s_ready3", 64'(bus.s_ready), 64'd1);
    tick();
    check("bp.done", 64'(bus.m_valid), 64'd0);

    // Back-to-back single-hit vectors with no gap.
    bus.s_match = 64'h1;
    bus.s_valid = 1'b1;
    tick();
    check_beat("b2b.a", 0, 1'b1, 1'b1);
    bus.s_match = 64'h80;
    #1;
    check("b2b.s_ready", 64'(bus.s_ready), 64'd1);
    tick();
    bus.s_valid = 1'b0;
    check_beat("b2b.b", 7, 1'b1, 1'b1);
    tick();
    check("b2b.done", 64'(bus.m_valid), 64'd0);

    // Scoreboarded drain of bits 1, 8, 61, 63 under random backpressure.
    bus.s_match = 64'hA000_0000_0000_0102;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    exp_q.push_back({6'd1,  1'b0});
    exp_q.push_back({6'd8,  1'b0});
    exp_q.push_back({6'd61, 1'b0});
    exp_q.push_back({6'd63, 1'b1});
    drain_scoreboard("sb");
    bus.m_ready = 1'b1;
    tick();
    check("sb.done", 64'(bus.m_valid), 64'd0);

    // Reset in the middle of draining an all-ones vector.
    bus.s_match = '1;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_beat($sformatf("mid.b%0d", i), i, 1'b1, 1'b0);
      if (i < 4) tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.async_valid", 64'(bus.m_valid), 64'd0);
    check("mid.async_state", 64'(dbg_state),   64'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid.stale%0d", i), 64'(bus.m_valid), 64'd0);
    end
    bus.s_match = 64'h4;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    check_beat("mid.new", 2, 1'b1, 1'b1);
    tick();
    check("mid.done", 64'(bus.m_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
